// File: rtl/spi_master_pkg.sv
// Shared types, parameter limits and counter sizing for the SPI master link.
package spi_master_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

  localparam int DATA_W_MIN  = 8;
  localparam int DATA_W_MAX  = 32;
  localparam int CLK_DIV_MIN = 1;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Reloadable down-counter: one-cycle tick every CLK_DIV enabled cycles, held at reload while cleared.
module spi_half_tick
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= RELOAD;
    end else if (clr || tick) begin
      cnt_reg <= RELOAD;
    end else if (en) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_link.sv
// SPI mode-0 master, MSB first: one full-duplex DATA_W-bit word per accepted request.
module spi_master_link
  import spi_master_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              spi_SCLK,
  output logic              spi_MOSI,
  input  logic              spi_MISO,
  output logic              spi_SS_n
);

  generate
    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || CLK_DIV < CLK_DIV_MIN) begin : g_param_check
      $error("spi_master_link: DATA_W must be 8..32 and CLK_DIV must be >= 1");
    end
  endgenerate

  localparam int BIT_W = cnt_width(DATA_W);

  state_t            state_reg, state_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] tx_sh_reg, tx_sh_next;
  logic [DATA_W-1:0] rx_sh_reg, rx_sh_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              sclk_reg, sclk_next;
  logic              mosi_reg, mosi_next;
  logic              ss_n_reg, ss_n_next;
  logic              tx_ready_reg, tx_ready_next;
  logic              busy_reg, busy_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              accept;
  logic              tick;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .en    (state_reg != IDLE),
    .clr   (state_reg == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      rx_data_reg  <= '0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      ss_n_reg     <= 1'b1;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_sh_reg    <= tx_sh_next;
      rx_sh_reg    <= rx_sh_next;
      rx_data_reg  <= rx_data_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      ss_n_reg     <= ss_n_next;
      tx_ready_reg <= tx_ready_next;
      busy_reg     <= busy_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  // bit_cnt counts bits whose SCLK falling edge is still ahead.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_sh_next    = tx_sh_reg;
    rx_sh_next    = rx_sh_reg;
    rx_data_next  = rx_data_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    ss_n_next     = ss_n_reg;
    tx_ready_next = tx_ready_reg;
    busy_next     = busy_reg;
    rx_valid_next = 1'b0;
    accept        = 1'b0;

    case (state_reg)
      IDLE: begin
        accept = tx_valid && tx_ready_reg;
      end
      SETUP: begin
        if (tick) begin
          sclk_next  = 1'b1;
          rx_sh_next = {rx_sh_reg[DATA_W-2:0], spi_MISO};
          state_next = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (sclk_reg) begin
            sclk_next    = 1'b0;
            bit_cnt_next = bit_cnt_reg - BIT_W'(1);
            if (bit_cnt_reg != BIT_W'(1)) begin
              tx_sh_next = {tx_sh_reg[DATA_W-2:0], 1'b0};
              mosi_next  = tx_sh_reg[DATA_W-2];
            end
          end else if (bit_cnt_reg == '0) begin
            ss_n_next     = 1'b1;
            mosi_next     = 1'b0;
            rx_valid_next = 1'b1;
            rx_data_next  = rx_sh_reg;
            state_next    = GAP;
          end else begin
            sclk_next  = 1'b1;
            rx_sh_next = {rx_sh_reg[DATA_W-2:0], spi_MISO};
          end
        end
      end
      GAP: begin
        // A request already waiting is taken on the gap's last edge so
        // back-to-back words keep SS_n high for exactly one half period.
        if (tick) begin
          if (tx_valid) begin
            accept = 1'b1;
          end else begin
            tx_ready_next = 1'b1;
            busy_next     = 1'b0;
            state_next    = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      tx_sh_next    = tx_data;
      mosi_next     = tx_data[DATA_W-1];
      bit_cnt_next  = BIT_W'(DATA_W);
      ss_n_next     = 1'b0;
      tx_ready_next = 1'b0;
      busy_next     = 1'b1;
      state_next    = SETUP;
    end
  end

  assign tx_ready = tx_ready_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_data  = rx_data_reg;
  assign busy     = busy_reg;
  assign spi_SCLK = sclk_reg;
  assign spi_MOSI = mosi_reg;
  assign spi_SS_n = ss_n_reg;

endmodule

// File: tb/tb_spi_master_link.sv
// Randomized bench for spi_master_link: an SPI slave model plus word-level expectations.
module tb_spi_master_link;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int W2 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // DUT A: 8-bit words, half period 2
  logic         a_rst_n, a_tx_valid, a_tx_ready, a_rx_valid, a_busy;
  logic         a_sclk, a_mosi, a_ss_n;
  logic         a_miso = 1'b0;
  logic [W-1:0] a_tx_data, a_rx_data;

  spi_master_link #(.DATA_W(W), .CLK_DIV(H)) dut_a (
    .clk_clk       (clk),
    .reset_reset_n (a_rst_n),
    .tx_valid      (a_tx_valid),
    .tx_ready      (a_tx_ready),
    .tx_data       (a_tx_data),
    .rx_valid      (a_rx_valid),
    .rx_data       (a_rx_data),
    .busy          (a_busy),
    .spi_SCLK      (a_sclk),
    .spi_MOSI      (a_mosi),
    .spi_MISO      (a_miso),
    .spi_SS_n      (a_ss_n)
  );

  // DUT B: 32-bit words, half period 1, MISO looped back from MOSI
  logic          b_rst_n, b_tx_valid, b_tx_ready, b_rx_valid, b_busy;
  logic          b_sclk, b_mosi, b_ss_n, b_miso;
  logic [W2-1:0] b_tx_data, b_rx_data;

  assign b_miso = b_mosi;

  spi_master_link #(.DATA_W(W2), .CLK_DIV(1)) dut_b (
    .clk_clk       (clk),
    .reset_reset_n (b_rst_n),
    .tx_valid      (b_tx_valid),
    .tx_ready      (b_tx_ready),
    .tx_data       (b_tx_data),
    .rx_valid      (b_rx_valid),
    .rx_data       (b_rx_data),
    .busy          (b_busy),
    .spi_SCLK      (b_sclk),
    .spi_MOSI      (b_mosi),
    .spi_MISO      (b_miso),
    .spi_SS_n      (b_ss_n)
  );

  // Expected transfers: {word master sends, word slave returns}
  logic [15:0]  pend_q[$];
  logic [15:0]  pair;
  logic [W-1:0] cur_tx = '0, cur_sl = '0, sl_sh = '0, mosi_cap = '0;
  int  e0 = 0, rises = 0, ss_falls = 0, last_ss_rise = 0, gap_len = 0, rxv_count = 0;
  logic prev_sclk = 1'b0, prev_ss = 1'b1, prev_rdy = 1'b1, prev_rxv = 1'b0;

  always @(negedge clk) begin
    if (!a_rst_n) begin
      a_miso = 1'b0;
    end else begin
      if (prev_rxv) check_val("rxv_pulse", a_rx_valid, 0);
      if (prev_ss && !a_ss_n) begin
        ss_falls++;
        gap_len  = cyc - last_ss_rise;
        e0       = cyc;
        rises    = 0;
        mosi_cap = '0;
        if (pend_q.size() > 0) begin
          pair   = pend_q.pop_front();
          cur_tx = pair[15:8];
          cur_sl = pair[7:0];
        end
        sl_sh  = cur_sl;
        a_miso = sl_sh[W-1];
      end
      if (!prev_ss && a_ss_n) last_ss_rise = cyc;
      if (!prev_sclk && a_sclk) begin
        mosi_cap = {mosi_cap[W-2:0], a_mosi};
        rises++;
      end
      if (prev_sclk && !a_sclk) begin
        sl_sh  = sl_sh << 1;
        a_miso = sl_sh[W-1];
      end
      if (a_rx_valid) begin
        rxv_count++;
        $display("xfer %0d: sent=0x%02h received=0x%02h rx_valid_at=E0+%0d",
                 rxv_count, mosi_cap, a_rx_data, cyc - e0);
        check_val("rx_data", a_rx_data, cur_sl);
        check_val("mosi_bits", mosi_cap, cur_tx);
        check_val("sclk_rises", rises, W);
        check_val("rxv_latency", cyc - e0, H + 2 * H * W);
      end
      if (!prev_rdy && a_tx_ready) check_val("ready_latency", cyc - e0, 2 * H + 2 * H * W);
    end
    prev_sclk = a_sclk;
    prev_ss   = a_ss_n;
    prev_rdy  = a_tx_ready;
    prev_rxv  = a_rx_valid;
  end

  int b_ss_low = 0, b_rises = 0, b_last_rise = -1, b_gap_min = 1000, b_gap_max = 0, b_rxv = 0;
  logic b_prev_sclk = 1'b0;
  logic [W2-1:0] b_rx_word = '0;

  always @(negedge clk) begin
    if (b_rst_n) begin
      if (!b_ss_n) b_ss_low++;
      if (!b_prev_sclk && b_sclk) begin
        b_rises++;
        if (b_last_rise >= 0) begin
          if (cyc - b_last_rise < b_gap_min) b_gap_min = cyc - b_last_rise;
          if (cyc - b_last_rise > b_gap_max) b_gap_max = cyc - b_last_rise;
        end
        b_last_rise = cyc;
      end
      if (b_rx_valid) begin
        b_rxv++;
        b_rx_word = b_rx_data;
        $display("xfer32: received=0x%08h", b_rx_data);
      end
    end
    b_prev_sclk = b_sclk;
  end

  task automatic tick_wait();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fall(input int n_before, input string tag);
    int t = 0;
    while (ss_falls == n_before && t < 200) begin tick_wait(); t++; end
    if (ss_falls == n_before) check_val(tag, 0, 1);
  endtask

  task automatic wait_rxv(input int target, input string tag);
    int t = 0;
    while (rxv_count < target && t < 400) begin tick_wait(); t++; end
    if (rxv_count < target) check_val(tag, rxv_count, target);
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!a_tx_ready && t < 100) begin tick_wait(); t++; end
    if (!a_tx_ready) check_val(tag, a_tx_ready, 1);
  endtask

  task automatic send(input logic [W-1:0] tx, input logic [W-1:0] sl, input bit change_after);
    int n = ss_falls;
    int r = rxv_count;
    pend_q.push_back({tx, sl});
    a_tx_data  = tx;
    a_tx_valid = 1'b1;
    wait_fall(n, "accept_timeout");
    a_tx_valid = 1'b0;
    if (change_after) begin
      tick_wait();
      a_tx_data = 8'hFF;
    end
    wait_rxv(r + 1, "rxv_timeout");
    wait_ready("ready_timeout");
  endtask

  int first_e0;
  int r0;
  int t;

  initial begin
    a_rst_n = 1'b0; a_tx_valid = 1'b0; a_tx_data = '0;
    b_rst_n = 1'b0; b_tx_valid = 1'b0; b_tx_data = '0;
    repeat (3) tick_wait();
    check_val("rst_tx_ready", a_tx_ready, 1);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_rx_valid", a_rx_valid, 0);
    check_val("rst_rx_data", a_rx_data, 0);
    check_val("rst_ss_n", a_ss_n, 1);
    check_val("rst_sclk", a_sclk, 0);
    check_val("rst_mosi", a_mosi, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    repeat (2) tick_wait();

    send(8'hA5, 8'h3C, 1'b0);
    tick_wait();

    // Back-to-back: valid held high across two words
    r0 = rxv_count;
    pend_q.push_back({8'h00, 8'hC3});
    pend_q.push_back({8'hFF, 8'h5A});
    a_tx_data  = 8'h00;
    a_tx_valid = 1'b1;
    wait_fall(ss_falls, "b2b_accept1_timeout");
    first_e0 = e0;
    a_tx_data = 8'hFF;
    wait_fall(ss_falls, "b2b_accept2_timeout");
    a_tx_valid = 1'b0;
    check_val("b2b_period", e0 - first_e0, 2 * H + 2 * H * W);
    check_val("b2b_ss_gap", gap_len, H);
    wait_rxv(r0 + 2, "b2b_rxv_timeout");
    wait_ready("b2b_ready_timeout");
    tick_wait();

    // Reset in the middle of bit 3 of 0x5A
    r0 = rxv_count;
    pend_q.push_back({8'h5A, 8'h99});
    a_tx_data  = 8'h5A;
    a_tx_valid = 1'b1;
    wait_fall(ss_falls, "rst_accept_timeout");
    a_tx_valid = 1'b0;
    t = 0;
    while (!(rises == 4 && a_sclk) && t < 100) begin tick_wait(); t++; end
    check_val("reach_bit3", rises, 4);
    check_val("bit3_mosi_pre", a_mosi, 1);
    a_rst_n = 1'b0;
    #1;
    check_val("abort_ss_n", a_ss_n, 1);
    check_val("abort_sclk", a_sclk, 0);
    check_val("abort_mosi", a_mosi, 0);
    check_val("abort_tx_ready", a_tx_ready, 1);
    check_val("abort_busy", a_busy, 0);
    repeat (3) tick_wait();
    a_rst_n = 1'b1;
    repeat (40) tick_wait();
    check_val("abort_no_rxv", rxv_count, r0);
    send(8'h81, 8'h7E, 1'b0);
    tick_wait();

    // tx_data changes after accept must not leak onto MOSI
    send(8'h0F, 8'hE1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick_wait();
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    // 32-bit loopback at the fastest SCLK
    b_tx_data  = 32'hDEADBEEF;
    b_tx_valid = 1'b1;
    t = 0;
    while (b_ss_n && t < 50) begin tick_wait(); t++; end
    check_val("b_accept", b_ss_n, 0);
    b_tx_valid = 1'b0;
    t = 0;
    while (!(b_rxv == 1 && b_tx_ready) && t < 200) begin tick_wait(); t++; end
    check_val("b_rxv_count", b_rxv, 1);
    check_val("b_rx_data", b_rx_word, 32'hDEADBEEF);
    check_val("b_ss_low", b_ss_low, 1 + 2 * W2);
    check_val("b_rises", b_rises, W2);
    check_val("b_period_min", b_gap_min, 2);
    check_val("b_period_max", b_gap_max, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master_link.md
# spi_master_link

FPGA-side SPI master that drives one full-duplex word transfer per accepted request, SPI mode 0 (CPOL=0, CPHA=0), MSB first. It is the initiator counterpart of the Raspberry Pi SPI slave port. It sits in the fabric next to the HPS/Qsys system and lets fabric logic or a PIO bridge talk to an external SPI slave, including the Pi link in loopback test setups. A valid/ready request side and a one-cycle received-word pulse connect it to user logic.

## Interface
- DATA_W, 32: bits per transfer, 8..32.
- CLK_DIV, 4: SCLK half-period in clk_clk cycles, ≥1. SCLK frequency = f(clk_clk) / (2·CLK_DIV).
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  request a transfer with tx_data.
- tx_ready  out  1  block can accept a request.
- tx_data  in  DATA_W  word to shift out. Sampled only on accept.
- rx_valid  out  1  one-cycle pulse: rx_data holds the word received in the just-finished transfer.
- rx_data  out  DATA_W  last received word. Held until the next rx_valid.
- busy  out  1  high from accept until tx_ready reasserts.
- spi_SCLK  out  1  serial clock, idle low.
- spi_MOSI  out  1  master data out.
- spi_MISO  in  1  slave data in.
- spi_SS_n  out  1  slave select, active low.

## Operation
- States:
  - IDLE: tx_ready=1. The block accepts when tx_valid&tx_ready is sampled high.
  - SETUP: SS_n low, SCLK low, H=CLK_DIV cycles.
  - XFER: DATA_W bits. Each bit is H cycles with SCLK high, then H cycles with SCLK low.
  - HOLD: merged with the last bit's low phase.
  - GAP: SS_n high, H cycles.
  - After GAP the block returns to IDLE.
- All outputs are registered. Reset values: tx_ready=1, rx_valid=0, rx_data=0, busy=0, spi_SCLK=0, spi_MOSI=0, spi_SS_n=1.
- Accept: tx_data is latched into the TX shift register. tx_data changes after accept have no effect.
- MOSI:
  - Changes only on clk edges where SCLK goes low, or at accept for bit W-1.
  - After the last bit it holds until SS_n rises, then goes 0.
- MISO:
  - Sampled on the clk edge that drives SCLK high and shifted into RX LSB.
  - No synchronizer. The slave is required to change MISO on the SCLK falling edge, which gives ≥H cycles of setup.
- tx_valid while busy is ignored, since tx_ready=0. No queueing.
- Back-to-back requests always deassert SS_n for exactly H cycles between words.
- Reset asserted mid-transfer: all outputs go to reset values immediately and asynchronously. No rx_valid is produced, and the partial word is discarded.
- Bit counter: ceil(log2(DATA_W+1)) bits. Half-period counter: ceil(log2(CLK_DIV+1)) bits. Neither wraps: both are reloaded per phase.

## Timing
Let E0 be the accepting clk edge and W=DATA_W.
- E0: SS_n←0, MOSI←tx_data[W-1], tx_ready←0, busy←1.
- Bit k (0..W-1):
  - SCLK←1 and MISO sampled at E0+H+2Hk.
  - SCLK←0 at E0+2H+2Hk, with MOSI←bit W-2-k if k<W-1.
- E0+H+2HW: SS_n←1, rx_valid←1, rx_data←received word.
- E0+H+2HW+1: rx_valid←0.
- E0+2H+2HW: tx_ready←1, busy←0. The earliest next accept is at this edge.
- SS_n is low for H+2HW cycles. The request-to-request period is 2H+2HW cycles.

## Structure
- spi_master_pkg holds:
  - the state enum (IDLE, SETUP, XFER, GAP);
  - the CLK_DIV and DATA_W range-check constants;
  - a function for the counter widths.
- Sub-module spi_half_tick: loadable down-counter producing a one-cycle tick every CLK_DIV cycles while enabled. It is cleared in IDLE.
- The FSM, shift registers and bit counter stay in spi_master_link.

## Test plan
- Reset with DATA_W=8, CLK_DIV=2 -> tx_ready=1, busy=0, rx_valid=0, rx_data=0x00, SS_n=1, SCLK=0, MOSI=0.
- Send 0xA5; slave model returns 0x3C -> MOSI on successive SCLK rising edges is 1,0,1,0,0,1,0,1. rx_valid pulses at E0+34 with rx_data=0x3C. tx_ready rises at E0+36.
- tx_valid held high with 0x00 then 0xFF -> second accept at E0+36. SS_n high for exactly 2 cycles between words. Both words are received correctly via the slave model.
- Reset asserted during bit 3 of 0x5A -> SS_n=1, SCLK=0, MOSI=0 immediately, no rx_valid. After release, 0x81 transfers correctly.
- tx_data changed to 0xFF one cycle after accepting 0x0F -> MOSI pattern matches 0x0F.
- DATA_W=32, CLK_DIV=1, MISO tied to MOSI, send 0xDEADBEEF -> rx_data=0xDEADBEEF. SS_n low for 65 cycles. SCLK period 2 cycles.
